// File: rtl/me_sad_search_pkg.sv
// Shared types and constants for the 4x4 full-search motion estimator.
package me_pkg;

   localparam int PIX_W  = 8;
   localparam int SAD_W  = 12;
   localparam int ADDR_W = 11;
   localparam int NPIX   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } me_state_t;

   // LSB of pixel (origin+i along addr_0, origin+j along addr_1) in a packed 4x4 block
   function automatic int pix_lsb(input int i, input int j);
      return (i * 4 + j) * PIX_W;
   endfunction

   function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/me_sad_search_if.sv
// Reference-frame memory 4x4 read port: the estimator is master, the memory is slave.
interface me_sad_search_if
   import me_pkg::*;
#(
   parameter int ADDR_W = me_pkg::ADDR_W
);

   logic [ADDR_W-1:0]       ref_addr_0;
   logic [ADDR_W-1:0]       ref_addr_1;
   logic                    ref_rd;
   logic [NPIX*PIX_W-1:0]   ref_rdata;

   modport master (
      output ref_addr_0,
      output ref_addr_1,
      output ref_rd,
      input  ref_rdata
   );

   modport slave (
      input  ref_addr_0,
      input  ref_addr_1,
      input  ref_rd,
      output ref_rdata
   );

endinterface

// File: rtl/me_sad_search_sad4x4.sv
// Registered 16-lane absolute difference plus adder tree; SAD of two packed 4x4 blocks, 1-cycle latency.
module me_sad4x4
   import me_pkg::*;
(
   input  logic                   clk,
   input  logic [NPIX*PIX_W-1:0]  cur,
   input  logic [NPIX*PIX_W-1:0]  ref_blk,
   output logic [SAD_W-1:0]       sad
);

   logic [PIX_W-1:0]   ad [NPIX];
   logic [PIX_W:0]     s_1 [8];
   logic [PIX_W+1:0]   s_2 [4];
   logic [PIX_W+2:0]   s_3 [2];
   logic [SAD_W-1:0]   sum;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ad[i*4+j] = absdiff(cur[pix_lsb(i, j) +: PIX_W], ref_blk[pix_lsb(i, j) +: PIX_W]);
         end
      end
   end

   // Each level widens by one bit, so 16 x 255 fits in 12 bits without overflow
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         s_1[k] = {1'b0, ad[2*k]} + {1'b0, ad[2*k+1]};
      end
      for (int k = 0; k < 4; k++) begin
         s_2[k] = {1'b0, s_1[2*k]} + {1'b0, s_1[2*k+1]};
      end
      for (int k = 0; k < 2; k++) begin
         s_3[k] = {1'b0, s_2[2*k]} + {1'b0, s_2[2*k+1]};
      end
      sum = {1'b0, s_3[0]} + {1'b0, s_3[1]};
   end

   always_ff @(posedge clk) begin
      sad <= sum;
   end

endmodule

// File: rtl/me_sad_search.sv
// Full-search 4x4 integer motion estimation over a +/-SEARCH_R window against a 4x4 reference read port.
// Build option: ME_EARLY_EXIT_EN ends the search as soon as a compared candidate has SAD 0.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing one legal candidate read per cycle
// DRAIN | last reads still in flight through the SAD pipeline (2 cycles)
// DONE  | results published on best_*, done pulsed
module me_sad_search
   import me_pkg::*;
#(
   parameter int SEARCH_R = 8,
   parameter int FRAME_W  = 1920,
   parameter int FRAME_H  = 1080,
   parameter int ADDR_W   = me_pkg::ADDR_W,
   parameter int MV_W     = $clog2(SEARCH_R) + 2
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        blk_0,
   input  logic [ADDR_W-1:0]        blk_1,
   input  logic [NPIX*PIX_W-1:0]    cur_blk,
   me_sad_search_if.master          ref_mem,
   output logic                     busy,
   output logic                     done,
   output logic signed [MV_W-1:0]   best_mv0,
   output logic signed [MV_W-1:0]   best_mv1,
   output logic [SAD_W-1:0]         best_sad
);

   typedef logic signed [ADDR_W:0] saddr_t;

   localparam saddr_t            R_S      = saddr_t'(SEARCH_R);
   localparam saddr_t            MAX_0    = saddr_t'(FRAME_W - 4);
   localparam saddr_t            MAX_1    = saddr_t'(FRAME_H - 4);
   localparam logic [SAD_W-1:0]  SAD_INIT = '1;

   me_state_t                state, state_n;

   saddr_t                   lo_0_s, hi_0_s, lo_1_s, hi_1_s;
   logic [ADDR_W-1:0]        blk_0_q, blk_1_q;
   logic [ADDR_W-1:0]        lo_0_q, hi_0_q, hi_1_q;
   logic [ADDR_W-1:0]        cand_0, cand_1;
   logic [NPIX*PIX_W-1:0]    cur_q;
   logic                     drain_cnt;

   logic                     accept, issue, last_cand;
   logic                     v_1, v_2, cmp_en, better, zero_hit;
   logic signed [MV_W-1:0]   mv0_iss, mv1_iss, mv0_1, mv1_1, mv0_2, mv1_2;
   logic [SAD_W-1:0]         sad_2;

   logic [SAD_W-1:0]         best_sad_q, best_sad_n;
   logic signed [MV_W-1:0]   best_mv0_q, best_mv1_q, best_mv0_n, best_mv1_n;

   // The legal window is a rectangle, so clamping its corners once at start
   // lets the scan walk only legal candidates and skip the rest for free.
   always_comb begin
      lo_0_s = saddr_t'({1'b0, blk_0}) - R_S;
      hi_0_s = saddr_t'({1'b0, blk_0}) + R_S;
      lo_1_s = saddr_t'({1'b0, blk_1}) - R_S;
      hi_1_s = saddr_t'({1'b0, blk_1}) + R_S;
      if (lo_0_s < saddr_t'(0)) lo_0_s = '0;
      if (hi_0_s > MAX_0)       hi_0_s = MAX_0;
      if (lo_1_s < saddr_t'(0)) lo_1_s = '0;
      if (hi_1_s > MAX_1)       hi_1_s = MAX_1;
   end

   me_sad4x4 u_sad (
      .clk     (clk),
      .cur     (cur_q),
      .ref_blk (ref_mem.ref_rdata),
      .sad     (sad_2)
   );

   assign cmp_en = v_2 && ((state == SCAN) || (state == DRAIN));
   assign better = cmp_en && (sad_2 < best_sad_q);

`ifdef ME_EARLY_EXIT_EN
   assign zero_hit = cmp_en && (sad_2 == '0);
`else
   assign zero_hit = 1'b0;
`endif

   assign accept    = (state == IDLE) && start;
   assign issue     = (state == SCAN) && !zero_hit;
   assign last_cand = (cand_0 == hi_0_q) && (cand_1 == hi_1_q);

   assign mv0_iss = MV_W'(saddr_t'({1'b0, cand_0}) - saddr_t'({1'b0, blk_0_q}));
   assign mv1_iss = MV_W'(saddr_t'({1'b0, cand_1}) - saddr_t'({1'b0, blk_1_q}));

   assign best_sad_n = better ? sad_2 : best_sad_q;
   assign best_mv0_n = better ? mv0_2 : best_mv0_q;
   assign best_mv1_n = better ? mv1_2 : best_mv1_q;

   assign ref_mem.ref_addr_0 = cand_0;
   assign ref_mem.ref_addr_1 = cand_1;
   assign ref_mem.ref_rd     = issue;
   assign busy               = (state == SCAN) || (state == DRAIN);
   assign done               = (state == DONE);

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (start) state_n = SCAN;
         end
         SCAN: begin
            if (zero_hit)       state_n = DONE;
            else if (last_cand) state_n = DRAIN;
         end
         DRAIN: begin
            if (zero_hit || (drain_cnt == 1'b0)) state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         blk_0_q    <= '0;
         blk_1_q    <= '0;
         lo_0_q     <= '0;
         hi_0_q     <= '0;
         hi_1_q     <= '0;
         cand_0     <= '0;
         cand_1     <= '0;
         cur_q      <= '0;
         drain_cnt  <= 1'b0;
         v_1        <= 1'b0;
         v_2        <= 1'b0;
         mv0_1      <= '0;
         mv1_1      <= '0;
         mv0_2      <= '0;
         mv1_2      <= '0;
         best_sad_q <= SAD_INIT;
         best_mv0_q <= '0;
         best_mv1_q <= '0;
         best_sad   <= '0;
         best_mv0   <= '0;
         best_mv1   <= '0;
      end else begin
         state <= state_n;
         v_1   <= issue;
         v_2   <= v_1;
         mv0_1 <= mv0_iss;
         mv1_1 <= mv1_iss;
         mv0_2 <= mv0_1;
         mv1_2 <= mv1_1;

         if ((state == SCAN) && (state_n == DRAIN)) begin
            drain_cnt <= 1'b1;
         end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt - 1'b1;
         end

         if (accept) begin
            blk_0_q    <= blk_0;
            blk_1_q    <= blk_1;
            cur_q      <= cur_blk;
            lo_0_q     <= ADDR_W'(lo_0_s);
            hi_0_q     <= ADDR_W'(hi_0_s);
            hi_1_q     <= ADDR_W'(hi_1_s);
            cand_0     <= ADDR_W'(lo_0_s);
            cand_1     <= ADDR_W'(lo_1_s);
            best_sad_q <= SAD_INIT;
            best_mv0_q <= '0;
            best_mv1_q <= '0;
         end else begin
            // The last candidate's address is held so ref_addr_* never leaves the frame
            if (issue && !last_cand) begin
               if (cand_0 == hi_0_q) begin
                  cand_0 <= lo_0_q;
                  cand_1 <= cand_1 + ADDR_W'(1);
               end else begin
                  cand_0 <= cand_0 + ADDR_W'(1);
               end
            end
            best_sad_q <= best_sad_n;
            best_mv0_q <= best_mv0_n;
            best_mv1_q <= best_mv1_n;
         end

         if ((state_n == DONE) && (state != DONE)) begin
            best_sad <= best_sad_n;
            best_mv0 <= best_mv0_n;
            best_mv1 <= best_mv1_n;
         end
      end
   end

endmodule

// File: tb/tb_me_sad_search.sv
// Self-checking bench for me_sad_search: directed table, hand-written corner sequences, random searches vs. a reference model.
module tb_me_sad_search;
   import me_pkg::*;

   localparam int R   = 8;
   localparam int FW  = 1920;
   localparam int FH  = 1080;
   localparam int AW  = 11;
   localparam int MVW = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic [AW-1:0]          blk_0, blk_1;
   logic [127:0]           cur_blk;
   logic                   busy, done;
   logic signed [MVW-1:0]  best_mv0, best_mv1;
   logic [11:0]            best_sad;

   me_sad_search_if #(.ADDR_W(AW)) ref_if ();

   me_sad_search #(
      .SEARCH_R (R),
      .FRAME_W  (FW),
      .FRAME_H  (FH),
      .ADDR_W   (AW),
      .MV_W     (MVW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .blk_0    (blk_0),
      .blk_1    (blk_1),
      .cur_blk  (cur_blk),
      .ref_mem  (ref_if),
      .busy     (busy),
      .done     (done),
      .best_mv0 (best_mv0),
      .best_mv1 (best_mv1),
      .best_sad (best_sad)
   );

   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_bad = 0;
   bit           flat_mode;
   logic [7:0]   flat_val;
   int unsigned  seed;
   int           rd_cnt, addr_bad, done_cnt, win_0, win_1;
   int           m_lat, m_rds, m_mv0, m_mv1, m_sad, m_busy1, m_busy_after, m_dones;

   function automatic logic [7:0] pix(input int x, input int y);
      int unsigned h;
      if (flat_mode) return flat_val;
      h = seed ^ (32'(x) * 32'd2654435761);
      h = h ^ (32'(y) * 32'd2246822519);
      h = h ^ (h >> 15);
      h = h * 32'd2246822519;
      h = h ^ (h >> 13);
      return h[7:0];
   endfunction

   function automatic logic [127:0] blk_at(input int x, input int y);
      logic [127:0] b;
      b = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            b[(i*4+j)*8 +: 8] = pix(x + i, y + j);
      return b;
   endfunction

   // Reference memory: data one cycle after rd; also watches addresses and done pulses
   initial ref_if.ref_rdata = '0;
   always @(posedge clk) begin
      if (ref_if.ref_rd) begin
         ref_if.ref_rdata <= blk_at(int'(ref_if.ref_addr_0), int'(ref_if.ref_addr_1));
         rd_cnt++;
         if (int'(ref_if.ref_addr_0) < win_0 - R || int'(ref_if.ref_addr_0) > win_0 + R ||
             int'(ref_if.ref_addr_1) < win_1 - R || int'(ref_if.ref_addr_1) > win_1 + R)
            addr_bad++;
      end
      if (int'(ref_if.ref_addr_0) > FW - 4 || int'(ref_if.ref_addr_1) > FH - 4) addr_bad++;
      if (done) done_cnt++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Exhaustive window walk straight from the rules: legality, SAD, strict-less update.
   task automatic model(input int b0, input int b1, input logic [127:0] cur,
                        output int e_mv0, output int e_mv1, output int e_sad,
                        output int e_lat, output int e_rds);
      int x, y, s, c, p, nleg, kzero;
      e_sad = 4096; e_mv0 = 0; e_mv1 = 0; nleg = 0; kzero = 0;
      for (int d1 = -R; d1 <= R; d1++) begin
         for (int d0 = -R; d0 <= R; d0++) begin
            x = b0 + d0;
            y = b1 + d1;
            if (x >= 0 && x <= FW - 4 && y >= 0 && y <= FH - 4) begin
               nleg++;
               s = 0;
               for (int i = 0; i < 4; i++)
                  for (int j = 0; j < 4; j++) begin
                     c = int'(cur[(i*4+j)*8 +: 8]);
                     p = int'(pix(x + i, y + j));
                     s += (c > p) ? c - p : p - c;
                  end
               if (s == 0 && kzero == 0) kzero = nleg;
               if (s < e_sad) begin e_sad = s; e_mv0 = d0; e_mv1 = d1; end
            end
         end
      end
`ifdef ME_EARLY_EXIT_EN
      e_lat = (kzero > 0) ? kzero + 3 : nleg + 3;
      e_rds = (kzero > 0) ? ((kzero + 1 < nleg) ? kzero + 1 : nleg) : nleg;
`else
      e_lat = nleg + 3;
      e_rds = nleg;
`endif
   endtask

   // One search; extra_at > 0 pulses a second start (with scrambled inputs) that many cycles in.
   task automatic run_search(input int b0, input int b1, input logic [127:0] cur,
                             input int extra_at, input int post_wait);
      int cyc;
      @(negedge clk);
      blk_0 = AW'(b0); blk_1 = AW'(b1); cur_blk = cur; start = 1'b1;
      win_0 = b0; win_1 = b1; rd_cnt = 0; addr_bad = 0; done_cnt = 0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      m_busy1 = int'(busy);
      blk_0 = AW'($urandom_range(0, FW - 4));
      blk_1 = AW'($urandom_range(0, FH - 4));
      cur_blk = {$urandom, $urandom, $urandom, $urandom};
      while (!done && cyc < 2000) begin
         if (cyc == extra_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      m_lat = done ? cyc : -1;
      m_rds = rd_cnt;
      m_mv0 = int'(best_mv0);
      m_mv1 = int'(best_mv1);
      m_sad = int'(best_sad);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_busy_after = int'(busy);
      repeat (post_wait) @(negedge clk);
      m_dones = done_cnt;
   endtask

   task automatic check_search(input string tag, input int e_lat, input int e_rds,
                               input int e_mv0, input int e_mv1, input int e_sad);
      chk({tag, " latency"}, m_lat, e_lat);
      chk({tag, " rd_count"}, m_rds, e_rds);
      chk({tag, " mv0"}, m_mv0, e_mv0);
      chk({tag, " mv1"}, m_mv1, e_mv1);
      chk({tag, " sad"}, m_sad, e_sad);
      chk({tag, " busy_c1"}, m_busy1, 1);
      chk({tag, " start_in_done_ignored"}, m_busy_after, 0);
      chk({tag, " done_pulses"}, m_dones, 1);
      chk({tag, " addr_range_violations"}, addr_bad, 0);
   endtask

   typedef struct {
      int          b0, b1;
      bit          flat;
      logic [7:0]  fref, fcur;
      int          o0, o1;
      int          e_mv0, e_mv1, e_sad, e_lat, e_rds;
   } vec_t;

   vec_t vt [6];

   initial begin
      int e_mv0, e_mv1, e_sad, e_lat, e_rds;
      int b0, b1, o0, o1, lo, hi;
      logic [127:0] cur;

      //           b0    b1    flat fref   fcur   o0  o1  mv0 mv1 sad  lat  rds
`ifdef ME_EARLY_EXIT_EN
      vt[0] = '{100,  100,  1, 8'h10, 8'h10,  0,  0, -8, -8,   0,   4,   2};
      vt[1] = '{100,  100,  1, 8'h10, 8'h25,  0,  0, -8, -8, 336, 292, 289};
      vt[2] = '{200,  300,  0, 8'h00, 8'h00,  3, -2,  3, -2,   0, 117, 115};
      vt[3] = '{0,    0,    0, 8'h00, 8'h00,  2,  5,  2,  5,   0,  51,  49};
      vt[4] = '{1916, 1076, 0, 8'h00, 8'h00, -3, -1, -3, -1,   0,  72,  70};
      vt[5] = '{0,    0,    1, 8'h40, 8'h40,  0,  0,  0,  0,   0,   4,   2};
`else
      vt[0] = '{100,  100,  1, 8'h10, 8'h10,  0,  0, -8, -8,   0, 292, 289};
      vt[1] = '{100,  100,  1, 8'h10, 8'h25,  0,  0, -8, -8, 336, 292, 289};
      vt[2] = '{200,  300,  0, 8'h00, 8'h00,  3, -2,  3, -2,   0, 292, 289};
      vt[3] = '{0,    0,    0, 8'h00, 8'h00,  2,  5,  2,  5,   0,  84,  81};
      vt[4] = '{1916, 1076, 0, 8'h00, 8'h00, -3, -1, -3, -1,   0,  84,  81};
      vt[5] = '{0,    0,    1, 8'h40, 8'h40,  0,  0,  0,  0,   0,  84,  81};
`endif

      rst = 1'b1; start = 1'b0; blk_0 = '0; blk_1 = '0; cur_blk = '0;
      flat_mode = 1'b1; flat_val = 8'h00; seed = 0;
      rd_cnt = 0; addr_bad = 0; done_cnt = 0; win_0 = 0; win_1 = 0;
      repeat (3) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset ref_rd", int'(ref_if.ref_rd), 0);
      chk("reset ref_addr_0", int'(ref_if.ref_addr_0), 0);
      chk("reset ref_addr_1", int'(ref_if.ref_addr_1), 0);
      chk("reset best_sad", int'(best_sad), 0);
      chk("reset best_mv0", int'(best_mv0), 0);
      chk("reset best_mv1", int'(best_mv1), 0);
      rst = 1'b0;

      for (int k = 0; k < 6; k++) begin
         flat_mode = vt[k].flat;
         flat_val  = vt[k].fref;
         seed      = $urandom;
         cur = vt[k].flat ? {16{vt[k].fcur}} : blk_at(vt[k].b0 + vt[k].o0, vt[k].b1 + vt[k].o1);
         run_search(vt[k].b0, vt[k].b1, cur, 0, 2);
         check_search($sformatf("vec%0d", k), vt[k].e_lat, vt[k].e_rds,
                      vt[k].e_mv0, vt[k].e_mv1, vt[k].e_sad);
      end

      // Second start while busy is ignored; only the first search's result appears
      flat_mode = 1'b0; seed = $urandom;
      cur = blk_at(500 - 5, 600 + 4);
      model(500, 600, cur, e_mv0, e_mv1, e_sad, e_lat, e_rds);
      run_search(500, 600, cur, 10, 350);
      check_search("restart_ignored", e_lat, e_rds, e_mv0, e_mv1, e_sad);

      // Reset in mid-scan aborts with no done, then a fresh search completes normally
      seed = $urandom;
      cur = blk_at(103, 98);
      @(negedge clk);
      blk_0 = AW'(100); blk_1 = AW'(100); cur_blk = cur; start = 1'b1;
      win_0 = 100; win_1 = 100;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("midscan busy before rst", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort busy", int'(busy), 0);
      chk("abort ref_rd", int'(ref_if.ref_rd), 0);
      chk("abort best_sad", int'(best_sad), 0);
      chk("abort best_mv0", int'(best_mv0), 0);
      chk("abort best_mv1", int'(best_mv1), 0);
      rst = 1'b0;
      done_cnt = 0;
      repeat (300) @(negedge clk);
      chk("abort no done", done_cnt, 0);
      model(100, 100, cur, e_mv0, e_mv1, e_sad, e_lat, e_rds);
      run_search(100, 100, cur, 0, 2);
      check_search("after_abort", e_lat, e_rds, e_mv0, e_mv1, e_sad);

      // Random searches, frame edges favoured
      for (int t = 0; t < 8; t++) begin
         flat_mode = 1'b0;
         seed = $urandom;
         case (t % 4)
            0:       begin b0 = int'($urandom_range(0, 7));         b1 = int'($urandom_range(0, FH - 4)); end
            1:       begin b0 = FW - 4 - int'($urandom_range(0, 7)); b1 = FH - 4 - int'($urandom_range(0, 7)); end
            2:       begin b0 = int'($urandom_range(0, FW - 4));    b1 = int'($urandom_range(0, 7)); end
            default: begin b0 = int'($urandom_range(0, FW - 4));    b1 = int'($urandom_range(0, FH - 4)); end
         endcase
         if (t % 2 == 0) begin
            lo = (b0 < R) ? -b0 : -R;
            hi = (FW - 4 - b0 < R) ? FW - 4 - b0 : R;
            o0 = lo + int'($urandom_range(0, hi - lo));
            lo = (b1 < R) ? -b1 : -R;
            hi = (FH - 4 - b1 < R) ? FH - 4 - b1 : R;
            o1 = lo + int'($urandom_range(0, hi - lo));
            cur = blk_at(b0 + o0, b1 + o1);
         end else begin
            cur = {$urandom, $urandom, $urandom, $urandom};
         end
         model(b0, b1, cur, e_mv0, e_mv1, e_sad, e_lat, e_rds);
         run_search(b0, b1, cur, 0, 2);
         check_search($sformatf("rnd%0d", t), e_lat, e_rds, e_mv0, e_mv1, e_sad);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
